// File: rtl/spi_msg_framer.sv
// spi_msg_framer
// Frames each complete message held in the upstream SPI FIFO as a 16-bit
// word stream:  SYNC_WORD, {SRC_ID, length}, payload words, ~checksum.
// The checksum is the one's complement of the 16-bit wraparound sum of the
// header word and every payload word. The sync word is not included.
//
// Ports
//   RST           async active-low reset
//   SYS_CLK       system clock, rising edge
//   GOT_FULL_MSG  upstream has a complete message waiting
//   MSG_LEN       payload word count, valid the cycle after MSG_START
//   FIFO_Q        upstream FIFO data, valid the cycle after RD_REQ
//   MSG_START     one-cycle pulse asking upstream to latch MSG_LEN
//   RD_REQ        one-cycle FIFO read strobe, one per payload word
//   OUT_DATA      frame word
//   OUT_VALID     OUT_DATA holds a word
//   OUT_READY     sink accepts the word on this edge
//   OUT_LAST      marks the checksum word
//   BUSY          framer is not idle
module spi_msg_framer #(
    parameter logic [7:0]  SRC_ID    = 8'h03,
    parameter logic [15:0] SYNC_WORD = 16'hA55A
) (
    input  logic        RST,
    input  logic        SYS_CLK,
    input  logic        GOT_FULL_MSG,
    input  logic [7:0]  MSG_LEN,
    input  logic [15:0] FIFO_Q,
    output logic        MSG_START,
    output logic        RD_REQ,
    output logic [15:0] OUT_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic        OUT_LAST,
    output logic        BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        LOAD,
        HDR0,
        HDR1,
        CAP,
        DATA,
        CSUM
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [7:0]  words_left;
    logic [7:0]  words_left_n;
    logic [15:0] csum_acc;
    logic [15:0] csum_acc_n;
    logic [15:0] out_data_n;
    logic        out_valid_n;
    logic        out_last_n;
    logic        msg_start_n;
    logic        xfer;

    assign xfer = OUT_VALID & OUT_READY;
    assign BUSY = (state != IDLE);

    always_ff @(posedge SYS_CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            words_left <= 8'd0;
            csum_acc   <= 16'd0;
            OUT_DATA   <= 16'd0;
            OUT_VALID  <= 1'b0;
            OUT_LAST   <= 1'b0;
            MSG_START  <= 1'b0;
        end else begin
            state      <= state_n;
            words_left <= words_left_n;
            csum_acc   <= csum_acc_n;
            OUT_DATA   <= out_data_n;
            OUT_VALID  <= out_valid_n;
            OUT_LAST   <= out_last_n;
            MSG_START  <= msg_start_n;
        end
    end

    // RD_REQ is decoded from the accepting transfer itself, so the FIFO
    // advances on that same edge and its word is already on FIFO_Q while
    // CAP samples it. Gating by the transfer also means a stalled sink
    // never triggers a read.
    always_comb begin
        state_n      = state;
        words_left_n = words_left;
        csum_acc_n   = csum_acc;
        out_data_n   = OUT_DATA;
        out_valid_n  = OUT_VALID;
        out_last_n   = OUT_LAST;
        msg_start_n  = 1'b0;
        RD_REQ       = 1'b0;

        case (state)
            IDLE: begin
                if (GOT_FULL_MSG) begin
                    msg_start_n = 1'b1;
                    state_n     = LATCH;
                end
            end
            LATCH: begin
                state_n = LOAD;
            end
            LOAD: begin
                words_left_n = MSG_LEN;
                if (MSG_LEN == 8'd0) begin
                    state_n = IDLE;
                end else begin
                    out_data_n  = SYNC_WORD;
                    out_valid_n = 1'b1;
                    state_n     = HDR0;
                end
            end
            HDR0: begin
                if (xfer) begin
                    out_data_n = {SRC_ID, words_left};
                    csum_acc_n = {SRC_ID, words_left};
                    state_n    = HDR1;
                end
            end
            HDR1: begin
                if (xfer) begin
                    out_valid_n = 1'b0;
                    RD_REQ      = 1'b1;
                    state_n     = CAP;
                end
            end
            CAP: begin
                out_data_n   = FIFO_Q;
                out_valid_n  = 1'b1;
                csum_acc_n   = csum_acc + FIFO_Q;
                words_left_n = words_left - 8'd1;
                state_n      = DATA;
            end
            DATA: begin
                if (xfer) begin
                    if (words_left == 8'd0) begin
                        out_data_n = ~csum_acc;
                        out_last_n = 1'b1;
                        state_n    = CSUM;
                    end else begin
                        out_valid_n = 1'b0;
                        RD_REQ      = 1'b1;
                        state_n     = CAP;
                    end
                end
            end
            CSUM: begin
                if (xfer) begin
                    out_valid_n = 1'b0;
                    out_last_n  = 1'b0;
                    state_n     = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_msg_framer.sv
// tb_spi_msg_framer
// Drives spi_msg_framer with a behavioural upstream (length latch plus a
// normal-mode FIFO) and a random-or-fixed ready sink. Every accepted word is
// logged and compared with the frame predicted from the FIFO contents.
module tb_spi_msg_framer;

    logic        RST;
    logic        SYS_CLK = 1'b0;
    logic        GOT_FULL_MSG;
    logic [7:0]  MSG_LEN;
    logic [15:0] FIFO_Q = 16'h0000;
    logic        MSG_START;
    logic        RD_REQ;
    logic [15:0] OUT_DATA;
    logic        OUT_VALID;
    logic        OUT_READY = 1'b1;
    logic        OUT_LAST;
    logic        BUSY;

    int total = 0;
    int bad   = 0;

    spi_msg_framer #(
        .SRC_ID    (8'h03),
        .SYNC_WORD (16'hA55A)
    ) dut (
        .RST          (RST),
        .SYS_CLK      (SYS_CLK),
        .GOT_FULL_MSG (GOT_FULL_MSG),
        .MSG_LEN      (MSG_LEN),
        .FIFO_Q       (FIFO_Q),
        .MSG_START    (MSG_START),
        .RD_REQ       (RD_REQ),
        .OUT_DATA     (OUT_DATA),
        .OUT_VALID    (OUT_VALID),
        .OUT_READY    (OUT_READY),
        .OUT_LAST     (OUT_LAST),
        .BUSY         (BUSY)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    // Upstream length register: loads the pending length on MSG_START.
    // len_poke scrambles it mid-frame to show it is not re-read.
    logic [7:0] pending_len = 8'd0;
    logic       len_poke    = 1'b0;
    always @(posedge SYS_CLK or negedge RST) begin
        if (!RST)           MSG_LEN <= 8'd0;
        else if (MSG_START) MSG_LEN <= pending_len;
        else if (len_poke)  MSG_LEN <= ~MSG_LEN;
    end

    // Normal-mode FIFO: word appears on FIFO_Q the cycle after RD_REQ.
    logic [15:0] fifo_mem [0:4095];
    int          wr_ptr = 0;
    int          rd_ptr = 0;
    always @(posedge SYS_CLK) begin
        if (RD_REQ === 1'b1) begin
            FIFO_Q <= fifo_mem[rd_ptr[11:0]];
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Sink ready: either a fixed level or a coin flip every cycle.
    bit ready_rand  = 1'b0;
    bit ready_level = 1'b1;
    always @(posedge SYS_CLK) begin
        #1;
        OUT_READY = ready_rand ? 1'($urandom_range(0, 1)) : ready_level;
    end

    // Monitor on the falling edge: what is valid and ready here is what the
    // next rising edge transfers.
    logic [15:0] cap_data [$];
    bit          cap_last [$];
    int          rd_cnt    = 0;
    int          ms_cnt    = 0;
    int          valid_cnt = 0;
    int          stall_err = 0;
    int          cyc       = 0;
    int          last_cyc  = 0;
    int          ms_cyc    = 0;
    bit          prev_stall = 1'b0;
    logic [15:0] prev_data  = 16'h0;
    bit          prev_last  = 1'b0;
    always @(negedge SYS_CLK) begin
        cyc++;
        if (RST === 1'b1) begin
            if (OUT_VALID && OUT_READY) begin
                cap_data.push_back(OUT_DATA);
                cap_last.push_back(OUT_LAST);
                if (OUT_LAST) last_cyc = cyc;
            end
            if (RD_REQ) rd_cnt++;
            if (MSG_START) begin
                ms_cnt++;
                ms_cyc = cyc;
            end
            if (OUT_VALID) valid_cnt++;
            if (prev_stall && (!OUT_VALID || OUT_DATA !== prev_data || OUT_LAST !== prev_last))
                stall_err++;
            prev_stall = OUT_VALID && !OUT_READY;
            prev_data  = OUT_DATA;
            prev_last  = OUT_LAST;
        end else begin
            prev_stall = 1'b0;
        end
    end

    logic [15:0] exp_words [$];

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic push_word(input logic [15:0] w);
        fifo_mem[wr_ptr[11:0]] = w;
        wr_ptr++;
    endtask

    task automatic launch(input logic [7:0] len, output bit timed_out);
        int ms0;
        ms0 = ms_cnt;
        pending_len  = len;
        GOT_FULL_MSG = 1'b1;
        timed_out    = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ms_cnt != ms0) begin
                timed_out = 1'b0;
                break;
            end
        end
        GOT_FULL_MSG = 1'b0;
    endtask

    task automatic wait_done(input int idx0, input int budget, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (cap_last.size() > idx0 && cap_last[cap_last.size() - 1]) begin
                timed_out = 1'b0;
                break;
            end
        end
        tick();
        tick();
    endtask

    // Reference frame: sync, header, payload as stored in the FIFO, then the
    // inverted 16-bit sum of header and payload.
    task automatic build_expect(input logic [7:0] len, input int rd0);
        logic [15:0] sum;
        logic [15:0] w;
        exp_words.delete();
        exp_words.push_back(16'hA55A);
        sum = {8'h03, len};
        exp_words.push_back(sum);
        for (int k = 0; k < int'(len); k++) begin
            w = fifo_mem[12'(rd0 + k)];
            exp_words.push_back(w);
            sum = sum + w;
        end
        exp_words.push_back(~sum);
    endtask

    task automatic test_reset();
        RST          = 1'b0;
        GOT_FULL_MSG = 1'b0;
        repeat (3) tick();
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("[TB] FAIL por_valid: got %b want 0", OUT_VALID); end
        total++; if (OUT_DATA !== 16'h0) begin bad++; $display("[TB] FAIL por_data: got %h want 0000", OUT_DATA); end
        total++; if (OUT_LAST !== 1'b0) begin bad++; $display("[TB] FAIL por_last: got %b want 0", OUT_LAST); end
        total++; if (MSG_START !== 1'b0) begin bad++; $display("[TB] FAIL por_msg_start: got %b want 0", MSG_START); end
        total++; if (RD_REQ !== 1'b0) begin bad++; $display("[TB] FAIL por_rd_req: got %b want 0", RD_REQ); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("[TB] FAIL por_busy: got %b want 0", BUSY); end
        RST = 1'b1;
        repeat (3) tick();
        total++; if (BUSY !== 1'b0) begin bad++; $display("[TB] FAIL idle_no_msg_busy: got %b want 0", BUSY); end
    endtask

    task automatic test_basic();
        logic [15:0] want [5];
        int idx0, rd0, ms0, n;
        bit to;
        want = '{16'hA55A, 16'h0302, 16'h0001, 16'h0002, 16'hFCFA};
        ready_rand  = 1'b0;
        ready_level = 1'b1;
        tick();
        push_word(16'h0001);
        push_word(16'h0002);
        idx0 = cap_data.size();
        rd0  = rd_cnt;
        ms0  = ms_cnt;
        launch(8'd2, to);
        total++; if (to) begin bad++; $display("[TB] FAIL basic_start: got no MSG_START want pulse"); end
        wait_done(idx0, 100, to);
        total++; if (to) begin bad++; $display("[TB] FAIL basic_done: got no LAST word want one"); end
        n = cap_data.size() - idx0;
        total++; if (n !== 5) begin bad++; $display("[TB] FAIL basic_count: got %0d want 5", n); end
        for (int i = 0; i < 5 && i < n; i++) begin
            total++;
            if (cap_data[idx0 + i] !== want[i]) begin
                bad++; $display("[TB] FAIL basic_word%0d: got %h want %h", i, cap_data[idx0 + i], want[i]);
            end
            total++;
            if (cap_last[idx0 + i] !== (i == 4)) begin
                bad++; $display("[TB] FAIL basic_last%0d: got %b want %b", i, cap_last[idx0 + i], (i == 4));
            end
        end
        total++; if (rd_cnt - rd0 !== 2) begin bad++; $display("[TB] FAIL basic_rd_req: got %0d want 2", rd_cnt - rd0); end
        total++; if (ms_cnt - ms0 !== 1) begin bad++; $display("[TB] FAIL basic_msg_start: got %0d want 1", ms_cnt - ms0); end
    endtask

    task automatic test_backpressure();
        int idx0, rd0, rdc0, st0, n;
        bit to;
        ready_rand = 1'b1;
        for (int k = 0; k < 3; k++) push_word(16'($urandom));
        idx0 = cap_data.size();
        rd0  = rd_ptr;
        rdc0 = rd_cnt;
        st0  = stall_err;
        launch(8'd3, to);
        total++; if (to) begin bad++; $display("[TB] FAIL bp_start: got no MSG_START want pulse"); end
        tick();
        len_poke = 1'b1;
        tick();
        len_poke = 1'b0;
        wait_done(idx0, 400, to);
        total++; if (to) begin bad++; $display("[TB] FAIL bp_done: got no LAST word want one"); end
        build_expect(8'd3, rd0);
        n = cap_data.size() - idx0;
        total++; if (n !== exp_words.size()) begin bad++; $display("[TB] FAIL bp_count: got %0d want %0d", n, exp_words.size()); end
        for (int i = 0; i < exp_words.size() && i < n; i++) begin
            total++;
            if (cap_data[idx0 + i] !== exp_words[i]) begin
                bad++; $display("[TB] FAIL bp_word%0d: got %h want %h", i, cap_data[idx0 + i], exp_words[i]);
            end
            total++;
            if (cap_last[idx0 + i] !== (i == exp_words.size() - 1)) begin
                bad++; $display("[TB] FAIL bp_last%0d: got %b", i, cap_last[idx0 + i]);
            end
        end
        total++; if (rd_cnt - rdc0 !== 3) begin bad++; $display("[TB] FAIL bp_rd_req: got %0d want 3", rd_cnt - rdc0); end
        total++; if (stall_err - st0 !== 0) begin bad++; $display("[TB] FAIL bp_stable: got %0d changes want 0", stall_err - st0); end
        ready_rand = 1'b0;
    endtask

    task automatic test_zero_len();
        int rdc0, v0, ms0;
        bit to;
        ready_rand  = 1'b0;
        ready_level = 1'b1;
        tick();
        rdc0 = rd_cnt;
        v0   = valid_cnt;
        ms0  = ms_cnt;
        launch(8'd0, to);
        total++; if (to) begin bad++; $display("[TB] FAIL zero_start: got no MSG_START want pulse"); end
        total++; if (BUSY !== 1'b1) begin bad++; $display("[TB] FAIL zero_busy_high: got %b want 1", BUSY); end
        repeat (2) tick();
        total++; if (BUSY !== 1'b0) begin bad++; $display("[TB] FAIL zero_busy_low: got %b want 0", BUSY); end
        repeat (4) tick();
        total++; if (valid_cnt - v0 !== 0) begin bad++; $display("[TB] FAIL zero_valid: got %0d cycles want 0", valid_cnt - v0); end
        total++; if (rd_cnt - rdc0 !== 0) begin bad++; $display("[TB] FAIL zero_rd_req: got %0d want 0", rd_cnt - rdc0); end
        total++; if (ms_cnt - ms0 !== 1) begin bad++; $display("[TB] FAIL zero_msg_start: got %0d want 1", ms_cnt - ms0); end
    endtask

    task automatic test_max_len();
        int idx0, rdc0, n, ones_bad, last_hi;
        bit to;
        ready_rand  = 1'b0;
        ready_level = 1'b1;
        for (int k = 0; k < 254; k++) push_word(16'hFFFF);
        idx0 = cap_data.size();
        rdc0 = rd_cnt;
        launch(8'd254, to);
        total++; if (to) begin bad++; $display("[TB] FAIL max_start: got no MSG_START want pulse"); end
        wait_done(idx0, 2000, to);
        total++; if (to) begin bad++; $display("[TB] FAIL max_done: got no LAST word want one"); end
        n = cap_data.size() - idx0;
        total++; if (n !== 257) begin bad++; $display("[TB] FAIL max_count: got %0d want 257", n); end
        if (n == 257) begin
            ones_bad = 0;
            last_hi  = 0;
            for (int i = 0; i < 257; i++) if (cap_last[idx0 + i]) last_hi++;
            for (int i = 2; i < 256; i++) if (cap_data[idx0 + i] !== 16'hFFFF) ones_bad++;
            total++; if (cap_data[idx0 + 1] !== 16'h03FE) begin bad++; $display("[TB] FAIL max_header: got %h want 03fe", cap_data[idx0 + 1]); end
            total++; if (ones_bad !== 0) begin bad++; $display("[TB] FAIL max_payload: got %0d wrong want 0", ones_bad); end
            total++; if (cap_data[idx0 + 256] !== 16'hFCFF) begin bad++; $display("[TB] FAIL max_csum: got %h want fcff", cap_data[idx0 + 256]); end
            total++; if (cap_last[idx0 + 256] !== 1'b1) begin bad++; $display("[TB] FAIL max_last_final: got %b want 1", cap_last[idx0 + 256]); end
            total++; if (last_hi !== 1) begin bad++; $display("[TB] FAIL max_last_count: got %0d want 1", last_hi); end
        end
        total++; if (rd_cnt - rdc0 !== 254) begin bad++; $display("[TB] FAIL max_rd_req: got %0d want 254", rd_cnt - rdc0); end
    endtask

    task automatic test_back_to_back();
        int a, b, idx0, idx1, rd0, rdc0, ms0, n;
        bit to;
        a = $urandom_range(1, 4);
        b = $urandom_range(1, 4);
        ready_rand  = 1'b0;
        ready_level = 1'b1;
        tick();
        for (int k = 0; k < a + b; k++) push_word(16'($urandom));
        idx0 = cap_data.size();
        rd0  = rd_ptr;
        rdc0 = rd_cnt;
        ms0  = ms_cnt;
        pending_len  = 8'(a);
        GOT_FULL_MSG = 1'b1;
        to = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ms_cnt != ms0) begin to = 1'b0; break; end
        end
        total++; if (to) begin bad++; $display("[TB] FAIL b2b_start1: got no MSG_START want pulse"); end
        pending_len = 8'(b);
        to = 1'b1;
        for (int c = 0; c < 200; c++) begin
            tick();
            if (ms_cnt - ms0 >= 2) begin to = 1'b0; break; end
        end
        GOT_FULL_MSG = 1'b0;
        total++; if (to) begin bad++; $display("[TB] FAIL b2b_start2: got no second MSG_START want pulse"); end
        n = cap_data.size() - idx0;
        total++; if (n !== a + 3) begin bad++; $display("[TB] FAIL b2b_first_done: got %0d words want %0d", n, a + 3); end
        total++; if (ms_cyc - last_cyc !== 2) begin bad++; $display("[TB] FAIL b2b_gap: got %0d want 2", ms_cyc - last_cyc); end
        idx1 = idx0 + a + 3;
        wait_done(idx1, 200, to);
        total++; if (to) begin bad++; $display("[TB] FAIL b2b_done: got no LAST word want one"); end
        build_expect(8'(a), rd0);
        for (int i = 0; i < exp_words.size() && idx0 + i < cap_data.size(); i++) begin
            total++;
            if (cap_data[idx0 + i] !== exp_words[i]) begin
                bad++; $display("[TB] FAIL b2b_f1_word%0d: got %h want %h", i, cap_data[idx0 + i], exp_words[i]);
            end
        end
        build_expect(8'(b), rd0 + a);
        n = cap_data.size() - idx1;
        total++; if (n !== exp_words.size()) begin bad++; $display("[TB] FAIL b2b_f2_count: got %0d want %0d", n, exp_words.size()); end
        for (int i = 0; i < exp_words.size() && i < n; i++) begin
            total++;
            if (cap_data[idx1 + i] !== exp_words[i]) begin
                bad++; $display("[TB] FAIL b2b_f2_word%0d: got %h want %h", i, cap_data[idx1 + i], exp_words[i]);
            end
        end
        total++; if (rd_cnt - rdc0 !== a + b) begin bad++; $display("[TB] FAIL b2b_rd_req: got %0d want %0d", rd_cnt - rdc0, a + b); end
    endtask

    task automatic test_reset_mid_frame();
        int idx0, idx1, rd0, ms0, n;
        bit to, hit;
        ready_rand  = 1'b0;
        ready_level = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) push_word(16'($urandom));
        idx0 = cap_data.size();
        launch(8'd5, to);
        total++; if (to) begin bad++; $display("[TB] FAIL rst_start: got no MSG_START want pulse"); end
        hit = 1'b0;
        for (int c = 0; c < 50; c++) begin
            tick();
            if (cap_data.size() >= idx0 + 3 && OUT_VALID === 1'b1) begin hit = 1'b1; break; end
        end
        total++; if (!hit) begin bad++; $display("[TB] FAIL rst_reach_data: got no payload phase want one"); end
        #2;
        RST = 1'b0;
        #1;
        total++; if (OUT_VALID !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", OUT_VALID); end
        total++; if (OUT_DATA !== 16'h0) begin bad++; $display("[TB] FAIL rst_data: got %h want 0000", OUT_DATA); end
        total++; if (OUT_LAST !== 1'b0) begin bad++; $display("[TB] FAIL rst_last: got %b want 0", OUT_LAST); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("[TB] FAIL rst_busy: got %b want 0", BUSY); end
        GOT_FULL_MSG = 1'b1;
        pending_len  = 8'd3;
        for (int k = 0; k < 3; k++) push_word(16'($urandom));
        repeat (2) tick();
        rd0  = rd_ptr;
        idx1 = cap_data.size();
        ms0  = ms_cnt;
        RST  = 1'b1;
        to = 1'b1;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (ms_cnt != ms0) begin to = 1'b0; break; end
        end
        GOT_FULL_MSG = 1'b0;
        total++; if (to) begin bad++; $display("[TB] FAIL rst_restart: got no MSG_START want pulse"); end
        wait_done(idx1, 100, to);
        total++; if (to) begin bad++; $display("[TB] FAIL rst_done: got no LAST word want one"); end
        build_expect(8'd3, rd0);
        n = cap_data.size() - idx1;
        total++; if (n !== exp_words.size()) begin bad++; $display("[TB] FAIL rst_count: got %0d want %0d", n, exp_words.size()); end
        for (int i = 0; i < exp_words.size() && i < n; i++) begin
            total++;
            if (cap_data[idx1 + i] !== exp_words[i]) begin
                bad++; $display("[TB] FAIL rst_word%0d: got %h want %h", i, cap_data[idx1 + i], exp_words[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            int len, idx0, rd0, rdc0, ms0, n;
            bit to;
            len        = $urandom_range(1, 12);
            ready_rand = 1'($urandom_range(0, 1));
            ready_level = 1'b1;
            tick();
            for (int k = 0; k < len; k++) push_word(16'($urandom));
            idx0 = cap_data.size();
            rd0  = rd_ptr;
            rdc0 = rd_cnt;
            ms0  = ms_cnt;
            launch(8'(len), to);
            total++; if (to) begin bad++; $display("[TB] FAIL rand%0d_start: got no MSG_START want pulse", f); end
            wait_done(idx0, 600, to);
            total++; if (to) begin bad++; $display("[TB] FAIL rand%0d_done: got no LAST word want one", f); end
            build_expect(8'(len), rd0);
            n = cap_data.size() - idx0;
            total++; if (n !== exp_words.size()) begin bad++; $display("[TB] FAIL rand%0d_count: got %0d want %0d", f, n, exp_words.size()); end
            for (int i = 0; i < exp_words.size() && i < n; i++) begin
                total++;
                if (cap_data[idx0 + i] !== exp_words[i]) begin
                    bad++; $display("[TB] FAIL rand%0d_word%0d: got %h want %h", f, i, cap_data[idx0 + i], exp_words[i]);
                end
                total++;
                if (cap_last[idx0 + i] !== (i == exp_words.size() - 1)) begin
                    bad++; $display("[TB] FAIL rand%0d_last%0d: got %b", f, i, cap_last[idx0 + i]);
                end
            end
            total++; if (rd_cnt - rdc0 !== len) begin bad++; $display("[TB] FAIL rand%0d_rd_req: got %0d want %0d", f, rd_cnt - rdc0, len); end
            total++; if (ms_cnt - ms0 !== 1) begin bad++; $display("[TB] FAIL rand%0d_msg_start: got %0d want 1", f, ms_cnt - ms0); end
        end
        ready_rand = 1'b0;
    endtask

    initial begin
        $display("[TB] starting spi_msg_framer bench");
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_max_len();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
